// File: rtl/acq_sequencer.sv
// Acquisition sequencer: schedules SPI conversions (periodic or single-shot) and walks
// the convert -> filter -> compare chain, with a per-stage watchdog and sticky status.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a period tick or single_shot request
// CONVERT | conversion requested, waiting for data_ready
// FILTER  | filter enabled, waiting for filter_done
// COMPARE | comparator enabled, waiting for compare_done
// DONE    | one-cycle completion: sample_valid pulse, count increment
module acq_sequencer #(
  parameter int PERIOD_W      = 16,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int TIMEOUT       = 255,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             single_shot,
  input  logic             err_clr,
  input  logic             data_ready,
  input  logic             filter_done,
  input  logic             compare_done,
  output logic             start_conversion,
  output logic             filter_enable,
  output logic             compare_enable,
  output logic             busy,
  output logic             sample_valid,
  output logic [CNT_W-1:0] sample_count,
  output logic [2:0]       stage,
  output logic             timeout_err,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_FILTER  = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]          WD_LAST     = 8'(TIMEOUT - 1);

  state_t              state, state_next;
  logic [PERIOD_W-1:0] period_cnt, period_cnt_next;
  logic [7:0]          wd_cnt, wd_cnt_next;
  logic                tick;
  logic                waiting;
  logic                wd_expired;
  logic                timeout_set;
  logic                overrun_set;

  always_comb begin
    tick            = run && (period_cnt == PERIOD_LAST);
    period_cnt_next = '0;
    if (run) begin
      period_cnt_next = (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;
    end

    state_next  = state;
    timeout_set = 1'b0;
    overrun_set = tick && (state != S_IDLE);
    waiting     = 1'b0;
    wd_expired  = (wd_cnt == WD_LAST);

    // A done input in the watchdog's last cycle takes priority over the abort.
    case (state)
      S_IDLE: begin
        if (tick || single_shot) state_next = S_CONVERT;
      end
      S_CONVERT: begin
        waiting = 1'b1;
        // start_conversion is high only in the first CONVERT cycle; data_ready is ignored there.
        if (data_ready && !start_conversion) begin
          state_next = S_FILTER;
        end else if (wd_expired) begin
          state_next  = S_IDLE;
          timeout_set = 1'b1;
        end
      end
      S_FILTER: begin
        waiting = 1'b1;
        if (filter_done) begin
          state_next = S_COMPARE;
        end else if (wd_expired) begin
          state_next  = S_IDLE;
          timeout_set = 1'b1;
        end
      end
      S_COMPARE: begin
        waiting = 1'b1;
        if (compare_done) begin
          state_next = S_DONE;
        end else if (wd_expired) begin
          state_next  = S_IDLE;
          timeout_set = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    wd_cnt_next = '0;
    if (waiting && (state_next == state)) begin
      wd_cnt_next = wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      period_cnt       <= '0;
      wd_cnt           <= '0;
      start_conversion <= 1'b0;
      filter_enable    <= 1'b0;
      compare_enable   <= 1'b0;
      busy             <= 1'b0;
      sample_valid     <= 1'b0;
      sample_count     <= '0;
      stage            <= 3'd0;
      timeout_err      <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state            <= state_next;
      period_cnt       <= period_cnt_next;
      wd_cnt           <= wd_cnt_next;
      start_conversion <= (state_next == S_CONVERT) && (state != S_CONVERT);
      filter_enable    <= (state_next == S_FILTER);
      compare_enable   <= (state_next == S_COMPARE);
      busy             <= (state_next != S_IDLE);
      sample_valid     <= (state_next == S_DONE);
      if (state_next == S_DONE) begin
        sample_count <= sample_count + 1'b1;
      end
      stage            <= state_next;
      // Set wins over a simultaneous clear.
      timeout_err      <= timeout_set | (timeout_err & ~err_clr);
      overrun          <= overrun_set | (overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed self-checking bench for acq_sequencer (SAMPLE_PERIOD=20, TIMEOUT=8, CNT_W=8).
module tb_acq_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, single_shot, err_clr;
  logic       data_ready, filter_done, compare_done;
  logic       start_conversion, filter_enable, compare_enable, busy, sample_valid;
  logic [7:0] sample_count;
  logic [2:0] stage;
  logic       timeout_err, overrun;

  int tests = 0;
  int fails = 0;

  logic [2:0] prev_stage = 3'd7;
  int         n_in = 0;

  int starts, valids, first_start, last_start, nvalid;

  acq_sequencer #(
    .PERIOD_W(16), .SAMPLE_PERIOD(20), .TIMEOUT(8), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .single_shot(single_shot), .err_clr(err_clr),
    .data_ready(data_ready), .filter_done(filter_done), .compare_done(compare_done),
    .start_conversion(start_conversion), .filter_enable(filter_enable),
    .compare_enable(compare_enable), .busy(busy), .sample_valid(sample_valid),
    .sample_count(sample_count), .stage(stage), .timeout_err(timeout_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stage, start_conversion, filter_enable, compare_enable, busy, sample_valid
  task automatic chk_st(input string tag, input logic [2:0] st, input logic s, input logic f,
                        input logic c, input logic b, input logic v);
    chk(tag, {24'd0, stage, start_conversion, filter_enable, compare_enable, busy, sample_valid},
        {24'd0, st, s, f, c, b, v});
  endtask

  // Reactive stage model: each done input fires 'hold' cycles after its stage is entered.
  task automatic drive(input int ncyc, input int hold, output int n_start, output int n_valid,
                       output int first, output int last);
    n_start = 0; n_valid = 0; first = -1; last = -1;
    for (int i = 0; i < ncyc; i++) begin
      if (stage != prev_stage) n_in = 0;
      else n_in++;
      prev_stage   = stage;
      data_ready   = (stage == 3'd1) && (n_in == hold);
      filter_done  = (stage == 3'd2) && (n_in == hold);
      compare_done = (stage == 3'd3) && (n_in == hold);
      if (start_conversion) begin
        n_start++;
        if (first < 0) first = i;
        last = i;
      end
      if (sample_valid) n_valid++;
      step();
    end
    data_ready = 0; filter_done = 0; compare_done = 0;
  endtask

  initial begin
    reset = 1; run = 0; single_shot = 0; err_clr = 0;
    data_ready = 0; filter_done = 0; compare_done = 0;
    step(); step();
    chk("reset_outs", {22'd0, stage, start_conversion, filter_enable, compare_enable, busy,
        sample_valid, timeout_err, overrun}, 32'd0);
    chk("reset_count", 32'(sample_count), 32'd0);
    reset = 0; step();

    // Single-shot acquisition with hand-timed done inputs
    single_shot = 1; step(); single_shot = 0;
    chk_st("ss_convert_entry", 3'd1, 1, 0, 0, 1, 0);
    data_ready = 1; step(); data_ready = 0;
    chk_st("ss_dr_first_ignored", 3'd1, 0, 0, 0, 1, 0);
    step(); step();
    data_ready = 1; step(); data_ready = 0;
    chk_st("ss_filter", 3'd2, 0, 1, 0, 1, 0);
    single_shot = 1; step(); single_shot = 0;
    step();
    filter_done = 1; step(); filter_done = 0;
    chk_st("ss_compare", 3'd3, 0, 0, 1, 1, 0);
    step();
    compare_done = 1; step(); compare_done = 0;
    chk_st("ss_done", 3'd4, 0, 0, 0, 1, 1);
    chk("ss_count", 32'(sample_count), 32'd1);
    step();
    chk_st("ss_idle", 3'd0, 0, 0, 0, 0, 0);
    step();
    chk_st("ss_busy_shot_ignored", 3'd0, 0, 0, 0, 0, 0);
    chk("ss_no_overrun", {30'd0, overrun, timeout_err}, 32'd0);

    // Stray done inputs while idle
    data_ready = 1; filter_done = 1; compare_done = 1;
    step(); step();
    data_ready = 0; filter_done = 0; compare_done = 0;
    chk_st("stray_idle", 3'd0, 0, 0, 0, 0, 0);
    chk("stray_count", 32'(sample_count), 32'd1);

    // Filter watchdog expiry
    single_shot = 1; step(); single_shot = 0;
    step();
    data_ready = 1; step(); data_ready = 0;
    chk_st("to_filter_entry", 3'd2, 0, 1, 0, 1, 0);
    repeat (7) step();
    chk_st("to_last_filter_cycle", 3'd2, 0, 1, 0, 1, 0);
    step();
    chk_st("to_abort", 3'd0, 0, 0, 0, 0, 0);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_count_unchanged", 32'(sample_count), 32'd1);

    // Reset in the middle of COMPARE
    single_shot = 1; step(); single_shot = 0;
    step();
    data_ready = 1; step(); data_ready = 0;
    filter_done = 1; step(); filter_done = 0;
    chk_st("rst_in_compare", 3'd3, 0, 0, 1, 1, 0);
    reset = 1; compare_done = 1; step(); reset = 0; compare_done = 0;
    chk("rst_outs", {22'd0, stage, start_conversion, filter_enable, compare_enable, busy,
        sample_valid, timeout_err, overrun}, 32'd0);
    chk("rst_count", 32'(sample_count), 32'd0);

    // Periodic run, done inputs 2 cycles after each enable
    run = 1;
    drive(110, 2, starts, valids, first_start, last_start);
    run = 0;
    chk("per_starts", 32'(starts), 32'd5);
    chk("per_valids", 32'(valids), 32'd5);
    chk("per_first_start", 32'(first_start), 32'd20);
    chk("per_last_start", 32'(last_start), 32'd100);
    chk("per_flags", {30'd0, overrun, timeout_err}, 32'd0);
    chk("per_count", 32'(sample_count), 32'd5);
    chk_st("per_idle", 3'd0, 0, 0, 0, 0, 0);

    // Stages held 7 cycles: a tick lands while busy; done arrives in the watchdog's last cycle
    reset = 1; step(); reset = 0;
    run = 1;
    drive(70, 7, starts, valids, first_start, last_start);
    chk("ovr_starts", 32'(starts), 32'd2);
    chk("ovr_last_start", 32'(last_start), 32'd60);
    chk("ovr_valids", 32'(valids), 32'd1);
    chk("ovr_flags", {30'd0, overrun, timeout_err}, 32'd2);
    run = 0;
    drive(40, 7, starts, valids, first_start, last_start);
    chk("runfall_starts", 32'(starts), 32'd0);
    chk("runfall_valids", 32'(valids), 32'd1);
    chk("runfall_count", 32'(sample_count), 32'd2);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    err_clr = 1; step(); err_clr = 0;
    chk("ovr_cleared", {30'd0, overrun, timeout_err}, 32'd0);

    // Count wrap over 256 single shots, data_ready held from the first CONVERT cycle
    reset = 1; step(); reset = 0;
    nvalid = 0;
    for (int i = 0; i < 256; i++) begin
      single_shot = 1; step(); single_shot = 0;
      data_ready = 1; step();
      if (i == 0) chk_st("wrap_first_cycle_ignored", 3'd1, 0, 0, 0, 1, 0);
      step(); data_ready = 0;
      if (i == 0) chk_st("wrap_filter", 3'd2, 0, 1, 0, 1, 0);
      filter_done = 1; step(); filter_done = 0;
      compare_done = 1; step(); compare_done = 0;
      if (sample_valid) nvalid++;
      step();
      if (i == 254) chk("wrap_count_255", 32'(sample_count), 32'd255);
    end
    chk("wrap_count_0", 32'(sample_count), 32'd0);
    chk("wrap_valids", 32'(nvalid), 32'd256);
    chk("wrap_flags", {30'd0, overrun, timeout_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
